// File: rtl/blk_mem_gen.sv
// blk_mem_gen: true dual-port synchronous block RAM, one clock.
//   Port A (ena/wea/addra/dina -> douta): data-path port.
//   Port B (enb/web/addrb/dinb -> doutb): host/configuration port.
// Each port has a registered, write-first read path with 1-cycle latency.
// Same-address collisions on one edge:
//   - both write: port A's data is the one stored.
//   - one writes, one reads: the reader sees the old word.
//   - both read: both see the same stored word.
// rst (async, active high) clears douta/doutb and blocks writes.
// It never touches the array contents.
module blk_mem_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] INIT_WORD = INIT_ZERO ? '0 : 'x;

  // The power-up value is carried as a declaration initialiser.
  // Block RAMs load this value at configuration time.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};

  logic wr_a, wr_b;
  assign wr_a = ena & wea;
  assign wr_b = enb & web;

  // Array write port: not reset, so contents survive rst.
  // Port B is written first and port A second.
  // On a same-address double write, the later nonblocking update (port A) wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_b) mem[addrb] <= dinb;
      if (wr_a) mem[addra] <= dina;
    end
  end

  // Output registers.
  // A read samples mem before this edge's nonblocking writes land.
  // That gives read-before-write across ports.
  // The writing port forwards its own din (write-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta <= '0;
      doutb <= '0;
    end else begin
      if (ena) douta <= wea ? dina : mem[addra];
      if (enb) doutb <= web ? dinb : mem[addrb];
    end
  end

endmodule

// File: tb/tb_blk_mem_gen.sv
// Directed plus randomized bench for blk_mem_gen.
// The reference model is a plain word array updated by the port rules.
// Reads take the pre-edge contents. Writes then apply B first, then A, so A wins.
module tb_blk_mem_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        ena, wea, enb, web;
  logic [9:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta, doutb;

  blk_mem_gen dut (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  always #5 clk = ~clk;

  logic [31:0] m [1024];
  logic [31:0] ea, eb;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic e, input logic w, input logic [9:0] a, input logic [31:0] d);
    ena = e; wea = w; addra = a; dina = d;
  endtask

  task automatic set_b(input logic e, input logic w, input logic [9:0] a, input logic [31:0] d);
    enb = e; web = w; addrb = a; dinb = d;
  endtask

  // Advance one edge with the current inputs, then compare both outputs.
  task automatic cyc(input string tag);
    logic [31:0] old_a, old_b;
    if (rst) begin
      ea = '0; eb = '0;
    end else begin
      old_a = m[addra];
      old_b = m[addrb];
      if (ena) ea = wea ? dina : old_a;
      if (enb) eb = web ? dinb : old_b;
      if (enb && web) m[addrb] = dinb;
      if (ena && wea) m[addra] = dina;
    end
    @(posedge clk);
    #1;
    chk({tag, "/A"}, douta, ea);
    chk({tag, "/B"}, doutb, eb);
  endtask

  logic [31:0] tbl [4];

  initial begin
    tbl[0] = 32'hB7ACF62C; tbl[1] = 32'hDEADBEEF;
    tbl[2] = 32'hFACE0001; tbl[3] = 32'h00000000;
    for (int i = 0; i < 1024; i++) m[i] = '0;
    ea = '0; eb = '0;
    rst = 1'b1;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    #1;
    chk("reset_a", douta, 32'h0);
    chk("reset_b", doutb, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("idle");

    // Untouched words read as zero.
    set_a(1, 0, 10'h155, '0); set_b(1, 0, 10'h2AA, '0);
    cyc("init_zero");

    // Port B burst write, then readback.
    set_a(0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      set_b(1, 1, 10'h21C + 10'(i), tbl[i]);
      cyc("b_burst_wr");
    end
    for (int i = 0; i < 4; i++) begin
      set_b(1, 0, 10'h21C + 10'(i), 32'h5A5A5A5A);
      cyc("b_burst_rd");
      chk("b_burst_rd_const", doutb, tbl[i]);
    end

    // Port A reads B-written data, then holds with ena=0.
    set_b(0, 0, '0, '0);
    set_a(1, 0, 10'h21D, '0);
    cyc("a_rd_b_data");
    chk("a_rd_const", douta, 32'hDEADBEEF);
    set_a(0, 1, 10'h000, 32'hFFFF0000);
    cyc("a_hold1");
    cyc("a_hold2");
    chk("a_hold_const", douta, 32'hDEADBEEF);

    // Write-first on port A.
    set_a(1, 1, 10'h010, 32'h12345678);
    cyc("a_wr_first");
    chk("a_wr_first_const", douta, 32'h12345678);
    set_a(1, 0, 10'h010, '0);
    cyc("a_rd_back");

    // Collisions on 0x020.
    set_a(0, 0, '0, '0); set_b(1, 1, 10'h020, 32'h11111111);
    cyc("coll_init");
    set_a(1, 1, 10'h020, 32'hAAAAAAAA); set_b(1, 1, 10'h020, 32'hBBBBBBBB);
    cyc("coll_ww");
    set_a(1, 0, 10'h020, '0); set_b(0, 0, '0, '0);
    cyc("coll_ww_rd");
    chk("coll_a_wins", douta, 32'hAAAAAAAA);
    set_a(1, 0, 10'h020, '0); set_b(1, 1, 10'h020, 32'hCCCCCCCC);
    cyc("coll_rw");
    chk("coll_rbw", douta, 32'hAAAAAAAA);
    set_b(1, 0, 10'h020, '0);
    cyc("coll_rr");
    chk("coll_rr_const", douta, 32'hCCCCCCCC);

    // Boundary addresses.
    set_a(1, 1, 10'h3FF, 32'hFFFFFFFF); set_b(1, 1, 10'h000, 32'h00000001);
    cyc("bnd_wr");
    set_a(1, 0, 10'h000, '0); set_b(1, 0, 10'h3FF, '0);
    cyc("bnd_rd");
    chk("bnd_0", douta, 32'h00000001);
    chk("bnd_3ff", doutb, 32'hFFFFFFFF);

    // enb=0 gates writes on port B.
    set_a(0, 0, '0, '0); set_b(0, 1, 10'h000, 32'hDEADBEEF);
    cyc("gate_b");
    set_b(1, 0, 10'h000, '0);
    cyc("gate_b_rd");
    chk("gate_b_const", doutb, 32'h00000001);

    // Async reset mid-cycle with nonzero outputs.
    // Writes are attempted while rst is held.
    set_a(0, 0, '0, '0); set_b(0, 0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_a", douta, 32'h0);
    chk("async_rst_b", doutb, 32'h0);
    ea = '0; eb = '0;
    set_a(1, 1, 10'h010, 32'h55555555); set_b(1, 1, 10'h21C, 32'h66666666);
    cyc("rst_nowrite");
    rst = 1'b0;
    set_a(1, 0, 10'h010, '0); set_b(1, 0, 10'h21C, '0);
    cyc("post_rst");
    chk("post_rst_a", douta, 32'h12345678);
    chk("post_rst_b", doutb, 32'hB7ACF62C);

    // Random traffic in a narrow window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      set_a(1'($urandom), 1'($urandom), 10'h100 + 10'($urandom_range(0, 7)), $urandom);
      set_b(1'($urandom), 1'($urandom), 10'h100 + 10'($urandom_range(0, 7)), $urandom);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
